// File: rtl/cell_frame_buffer_if.sv
// rtl/cell_frame_buffer_if.sv - write/read/clear bundle between the drawing logic, the VGA scanner and the frame buffer
//
// Signals (master = drawing/scan side, slave = frame buffer):
//   wr_en, wr_x, wr_y, wr_data : cell write request
//   wr_ready                   : writes are being accepted (not clearing)
//   rd_en, rd_x, rd_y          : cell read request
//   rd_data, rd_valid          : registered read result, one cycle after rd_en
//   clear                      : start a full-screen clear sweep
//   clear_busy                 : clear sweep in progress
interface cell_frame_buffer_if #(
  parameter int H_CELLS    = 80,
  parameter int V_CELLS    = 60,
  parameter int PIXEL_BITS = 1
);
  localparam int XW = $clog2(H_CELLS);
  localparam int YW = $clog2(V_CELLS);

  logic                  wr_en;
  logic [XW-1:0]         wr_x;
  logic [YW-1:0]         wr_y;
  logic [PIXEL_BITS-1:0] wr_data;
  logic                  wr_ready;
  logic                  rd_en;
  logic [XW-1:0]         rd_x;
  logic [YW-1:0]         rd_y;
  logic [PIXEL_BITS-1:0] rd_data;
  logic                  rd_valid;
  logic                  clear;
  logic                  clear_busy;

  modport master (
    output wr_en, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y, clear,
    input  wr_ready, rd_data, rd_valid, clear_busy
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_data, rd_en, rd_x, rd_y, clear,
    output wr_ready, rd_data, rd_valid, clear_busy
  );
endinterface

// File: rtl/cell_frame_buffer.sv
// rtl/cell_frame_buffer.sv - H_CELLS x V_CELLS colour-code frame buffer with registered read and sweeping clear
//
// Ports:
//   clk   : system clock, all logic on posedge
//   reset : synchronous, active-high; starts a full clear sweep on release
//   bus   : cell_frame_buffer_if.slave (write, read, clear request and status)
// Optional feature macro: FB_WRITE_BYPASS_EN
//   defined   -> same-cycle write/read to one address returns the new data
//   undefined -> read-before-write, the old content is returned
module cell_frame_buffer #(
  parameter int                    H_CELLS     = 80,
  parameter int                    V_CELLS     = 60,
  parameter int                    PIXEL_BITS  = 1,
  parameter logic [PIXEL_BITS-1:0] CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  cell_frame_buffer_if.slave    bus
);
  localparam int XW    = $clog2(H_CELLS);
  localparam int YW    = $clog2(V_CELLS);
  localparam int DEPTH = H_CELLS * V_CELLS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [AW-1:0] H_AW      = AW'(H_CELLS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic {
    IDLE,
    CLEARING
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         clr_addr_q, clr_addr_d;
  logic [PIXEL_BITS-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic [PIXEL_BITS-1:0] mem [DEPTH];

  logic                  clear_busy;
  logic                  wr_in_range, rd_in_range, wr_accept;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic                  ram_we;
  logic [AW-1:0]         ram_addr;
  logic [PIXEL_BITS-1:0] ram_wdata;

  assign clear_busy  = (state_q == CLEARING);

  assign wr_in_range = (32'(bus.wr_x) < H_CELLS) && (32'(bus.wr_y) < V_CELLS);
  assign rd_in_range = (32'(bus.rd_x) < H_CELLS) && (32'(bus.rd_y) < V_CELLS);
  assign wr_addr     = AW'(bus.wr_y) * H_AW + AW'(bus.wr_x);
  assign rd_addr     = AW'(bus.rd_y) * H_AW + AW'(bus.rd_x);
  assign wr_accept   = bus.wr_en && wr_in_range && !clear_busy;

  // Single write port: the clear sweep owns it while busy, user writes otherwise.
  assign ram_we    = clear_busy || wr_accept;
  assign ram_addr  = clear_busy ? clr_addr_q : wr_addr;
  assign ram_wdata = clear_busy ? CLEAR_VALUE : bus.wr_data;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end

  // Clear sequencer: one address per cycle, restartable by a new clear pulse.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d    = CLEARING;
          clr_addr_d = '0;
        end
      end
      CLEARING: begin
        if (bus.clear) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: begin
        state_d    = CLEARING;
        clr_addr_d = '0;
      end
    endcase
  end

  // Reads during a sweep blank to CLEAR_VALUE so the screen clears at once.
  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      if (rd_in_range && !clear_busy) begin
        rd_data_d = mem[rd_addr];
`ifdef FB_WRITE_BYPASS_EN
        if (wr_accept && (wr_addr == rd_addr)) begin
          rd_data_d = bus.wr_data;
        end
`endif
      end else begin
        rd_data_d = CLEAR_VALUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEARING;
      clr_addr_q <= '0;
      rd_data_q  <= CLEAR_VALUE;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.clear_busy = clear_busy;
  assign bus.wr_ready   = ~clear_busy;
endmodule
